// File: rtl/uart_cmd_parser.sv
// Purpose : frames the UART receiver byte stream into {opcode, length, payload, checksum}
//           commands, buffers the payload and presents validated commands downstream.
// Latency : a pending byte is consumed in its first pending cycle (rx_ack toggles at the next
//           edge); cmd_valid rises on the same edge that acknowledges the checksum byte;
//           rd_data is one cycle behind rd_addr.
// Backpressure: while cmd_valid is high no bytes are acknowledged, which stalls the receiver
//           until cmd_ack releases the command.
// Ports   : clk/n_reset                clock, async active-low reset
//           rx_valid/rx_data/rx_seq    receiver byte, stop-bit status, sequence toggle
//           rx_ack                     acknowledge toggle back to the receiver
//           cmd_valid/cmd_op/cmd_len   validated command, held until cmd_ack
//           rd_addr/rd_data            registered payload buffer read port
//           err/err_code               one-cycle abort pulse and its reason
module uart_cmd_parser #(
    parameter int MAXLEN  = 64,
    parameter int TIMEOUT = 65536,
    localparam int LW = $clog2(MAXLEN + 1),
    localparam int AW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1
) (
    input  logic          clk,
    input  logic          n_reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_seq,
    output logic          rx_ack,
    output logic          cmd_valid,
    output logic [7:0]    cmd_op,
    output logic [LW-1:0] cmd_len,
    input  logic          cmd_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          err,
    output logic [1:0]    err_code
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_SYNC, S_OP, S_LEN, S_DATA, S_SUM, S_CMD} state_t;

    state_t        state_q, state_d;
    logic          rx_ack_q, rx_ack_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_op_q, cmd_op_d;
    logic [LW-1:0] cmd_len_q, cmd_len_d;
    logic [7:0]    sum_q, sum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    rd_data_q;
    logic [7:0]    buf_q [MAXLEN];

    logic          pending, in_frame, take, wr_en, abort;
    logic [1:0]    abort_code;
    logic [7:0]    sum_chk;

    assign pending  = (rx_seq != rx_ack_q);
    assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);
    assign take     = pending && (in_frame || (state_q == S_OP));
    assign sum_chk  = sum_q + rx_data;

    always_comb begin
        state_d     = state_q;
        rx_ack_d    = rx_ack_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_len_d   = cmd_len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        tmo_d       = '0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        wr_en       = 1'b0;
        abort       = 1'b0;
        abort_code  = 2'd0;

        if (take) begin
            rx_ack_d = rx_seq;
        end
        // Inter-byte timer only runs mid-frame; any consumed byte restarts it.
        if (in_frame && !take) begin
            tmo_d = tmo_q + TW'(1);
        end

        case (state_q)
            S_SYNC: begin
                // Drop whatever byte the receiver held across reset.
                rx_ack_d = rx_seq;
                state_d  = S_OP;
            end
            S_CMD: begin
                if (cmd_ack) begin
                    cmd_valid_d = 1'b0;
                    state_d     = S_OP;
                end
            end
            default: begin
                if (take && !rx_valid) begin
                    abort      = 1'b1;
                    abort_code = 2'd1;
                end else if (take) begin
                    case (state_q)
                        S_OP: begin
                            cmd_op_d = rx_data;
                            sum_d    = rx_data;
                            state_d  = S_LEN;
                        end
                        S_LEN: begin
                            if (int'(rx_data) > MAXLEN) begin
                                abort      = 1'b1;
                                abort_code = 2'd2;
                            end else begin
                                cmd_len_d = LW'(rx_data);
                                sum_d     = sum_chk;
                                idx_d     = '0;
                                state_d   = (rx_data == 8'd0) ? S_SUM : S_DATA;
                            end
                        end
                        S_DATA: begin
                            wr_en = 1'b1;
                            sum_d = sum_chk;
                            idx_d = idx_q + AW'(1);
                            if (LW'(idx_q) + LW'(1) == cmd_len_q) begin
                                state_d = S_SUM;
                            end
                        end
                        S_SUM: begin
                            if (sum_chk == 8'd0) begin
                                cmd_valid_d = 1'b1;
                                state_d     = S_CMD;
                            end else begin
                                abort      = 1'b1;
                                abort_code = 2'd3;
                            end
                        end
                        default: ;
                    endcase
                end else if (in_frame && (tmo_q == TW'(TIMEOUT - 1))) begin
                    // A byte arriving in this same cycle takes the branch above instead.
                    abort      = 1'b1;
                    abort_code = 2'd0;
                end
            end
        endcase

        if (abort) begin
            err_d      = 1'b1;
            err_code_d = abort_code;
            state_d    = S_OP;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= S_SYNC;
            rx_ack_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= '0;
            cmd_len_q   <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            rx_ack_q    <= rx_ack_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_len_q   <= cmd_len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            rd_data_q   <= buf_q[rd_addr];
        end
    end

    // Payload storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[idx_q] <= rx_data;
        end
    end

    assign rx_ack    = rx_ack_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_len   = cmd_len_q;
    assign rd_data   = rd_data_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule
